// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, checks CRC-32 and length, drops the FCS,
// and emits payload bytes with sop/eop/err markers.
module gmii_rx_framer #(
    parameter int MIN_LEN = 60,
    parameter int MAX_LEN = 1514,
    parameter int MAX_PRE = 15
) (
    input  logic       clk_125mhz,
    input  logic       rst_n,
    input  logic [7:0] gmii_rxd,
    input  logic       gmii_rx_dv,
    input  logic       gmii_rx_err,
    output logic [7:0] rx_data,
    output logic       rx_vld,
    output logic       rx_sop,
    output logic       rx_eop,
    output logic       rx_err
);

    localparam int              PCW         = $clog2(MAX_PRE + 2);
    localparam logic [PCW-1:0]  PRE_LIM     = PCW'(MAX_PRE);
    localparam logic [31:0]     CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0]     CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [13:0]     CNT_MAX     = 14'h3FFF;
    localparam logic [13:0]     LEN_LO      = 14'(MIN_LEN + 4);
    localparam logic [13:0]     LEN_HI      = 14'(MAX_LEN + 4);
    localparam logic [7:0]      PRE_BYTE    = 8'h55;
    localparam logic [7:0]      SFD_BYTE    = 8'hD5;

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_t;

    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        return r;
    endfunction

    function automatic logic [13:0] sat_inc(input logic [13:0] v);
        return (v == CNT_MAX) ? v : v + 14'd1;
    endfunction

    state_t           r_state;
    state_t           w_next;
    logic [PCW-1:0]   r_pre_cnt;
    logic [PCW-1:0]   w_pre_inc;
    logic             w_pre_start;
    logic             w_pre_more;
    logic             w_sfd;
    logic             w_take;
    logic             w_eof;
    logic [3:0][7:0]  r_s;
    logic [2:0]       r_fill;
    logic [7:0]       r_pend;
    logic             r_pend_vld;
    logic             r_first;
    logic [31:0]      r_crc;
    logic [13:0]      r_cnt;
    logic             r_err;

    assign w_pre_inc = r_pre_cnt + PCW'(1);
    assign w_take    = (r_state == S_DATA) && gmii_rx_dv;
    assign w_eof     = (r_state == S_DATA) && !gmii_rx_dv;

    always_comb begin
        w_next      = r_state;
        w_pre_start = 1'b0;
        w_pre_more  = 1'b0;
        w_sfd       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (gmii_rx_dv) begin
                    if (gmii_rxd == PRE_BYTE) begin
                        w_next      = S_PRE;
                        w_pre_start = 1'b1;
                    end else if (gmii_rxd == SFD_BYTE) begin
                        w_next = S_DATA;
                        w_sfd  = 1'b1;
                    end else begin
                        w_next = S_DROP;
                    end
                end
            end
            S_PRE: begin
                if (!gmii_rx_dv) begin
                    w_next = S_IDLE;
                end else if (gmii_rxd == PRE_BYTE) begin
                    if (w_pre_inc > PRE_LIM) w_next = S_DROP;
                    else                     w_pre_more = 1'b1;
                end else if (gmii_rxd == SFD_BYTE) begin
                    w_next = S_DATA;
                    w_sfd  = 1'b1;
                end else begin
                    w_next = S_DROP;
                end
            end
            S_DATA: if (!gmii_rx_dv) w_next = S_IDLE;
            S_DROP: if (!gmii_rx_dv) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_125mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pre_cnt  <= '0;
            r_s        <= '0;
            r_fill     <= '0;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_first    <= 1'b0;
            r_crc      <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            rx_data    <= '0;
            rx_vld     <= 1'b0;
            rx_sop     <= 1'b0;
            rx_eop     <= 1'b0;
            rx_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            rx_vld  <= 1'b0;
            rx_sop  <= 1'b0;
            rx_eop  <= 1'b0;
            rx_err  <= 1'b0;
            if (w_pre_start)     r_pre_cnt <= PCW'(1);
            else if (w_pre_more) r_pre_cnt <= w_pre_inc;

            if (w_sfd) begin
                r_fill     <= '0;
                r_pend_vld <= 1'b0;
                r_first    <= 1'b1;
                r_crc      <= 32'hFFFF_FFFF;
                r_cnt      <= '0;
                r_err      <= 1'b0;
            end else if (w_take) begin
                // Four-byte delay line plus pending byte keeps the FCS from ever reaching the output
                if (r_pend_vld) begin
                    rx_data <= r_pend;
                    rx_vld  <= 1'b1;
                    rx_sop  <= r_first;
                    r_first <= 1'b0;
                end
                r_pend     <= r_s[3];
                r_pend_vld <= (r_fill == 3'd4);
                r_s        <= {r_s[2:0], gmii_rxd};
                if (r_fill != 3'd4) r_fill <= r_fill + 3'd1;
                r_crc      <= crc32_byte(r_crc, gmii_rxd);
                r_cnt      <= sat_inc(r_cnt);
                r_err      <= r_err | gmii_rx_err;
            end else if (w_eof) begin
                if (r_pend_vld) begin
                    rx_data <= r_pend;
                    rx_vld  <= 1'b1;
                    rx_sop  <= r_first;
                    rx_eop  <= 1'b1;
                    rx_err  <= r_err | (r_crc != CRC_RESIDUE) | (r_cnt < LEN_LO) | (r_cnt > LEN_HI);
                end
                r_first    <= 1'b0;
                r_pend_vld <= 1'b0;
                r_fill     <= '0;
            end
        end
    end

endmodule
